// File: rtl/rgb2bayer_pkg.sv
// Shared types and constants for the RGB-to-Bayer re-mosaic block.
package rgb2bayer_pkg;

   typedef enum logic [2:0] {
      WAIT_VS = 3'd0,
      WAIT_DE = 3'd1,
      ACTIVE  = 3'd2,
      DRAIN   = 3'd3,
      TRAIL   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_R  = 2'b00;
   localparam logic [1:0] SEL_GR = 2'b01;
   localparam logic [1:0] SEL_GB = 2'b10;
   localparam logic [1:0] SEL_B  = 2'b11;

   localparam logic [1:0] PAT_RGGB = 2'b00;
   localparam logic [1:0] PAT_GRBG = 2'b01;
   localparam logic [1:0] PAT_GBRG = 2'b10;
   localparam logic [1:0] PAT_BGGR = 2'b11;

   localparam int unsigned LEN_W = 12;

endpackage

// File: rtl/rgb2bayer_dly.sv
// Fixed-depth delay line for {de, rgb}; any_valid reports a stored de=1 anywhere in the line.
module rgb2bayer_dly #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 36
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         din_de,
   input  logic [W-1:0] din,
   output logic         dout_de,
   output logic [W-1:0] dout,
   output logic         any_valid
);

   logic [DEPTH-1:0] de_sr;
   logic [W-1:0]     data_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         de_sr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) data_sr[i] <= '0;
      end else begin
         de_sr[0]   <= din_de;
         data_sr[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            de_sr[i]   <= de_sr[i-1];
            data_sr[i] <= data_sr[i-1];
         end
      end
   end

   assign dout_de   = de_sr[DEPTH-1];
   assign dout      = data_sr[DEPTH-1];
   assign any_valid = |de_sr;

endmodule

// File: rtl/rgb2bayer.sv
// Re-mosaics a vsync/de RGB stream into raw Bayer with fv/lv framing and line-length checking.
module rgb2bayer
   import rgb2bayer_pkg::*;
#(
   parameter int unsigned DW       = 12,
   parameter logic [1:0]  PATTERN  = 2'b00,
   parameter int unsigned FV_LEAD  = 4,
   parameter int unsigned FV_TRAIL = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          de,
   input  logic [DW-1:0] rin,
   input  logic [DW-1:0] gin,
   input  logic [DW-1:0] bin,
   output logic          fv,
   output logic          lv,
   output logic [DW-1:0] dout,
   output logic          frame_done,
   output logic          err
);

   state_t            state;
   logic              vsync_q;
   logic              vs_rise;
   logic              accept;
   logic              masked;
   logic              masked_q;
   logic              frame_start;
   logic              d_de;
   logic [3*DW-1:0]   d_rgb;
   logic              any_valid;
   logic [3:0]        trail_cnt;
   logic              pix_par;
   logic              pix_cur;
   logic              line_par;
   logic [1:0]        sel;
   logic [DW-1:0]     pix;
   logic              lv_q;
   logic              lv_fall;
   logic              first_line;
   logic [LEN_W-1:0]  len_cnt;
   logic [LEN_W-1:0]  len_ref;

   assign vs_rise     = vsync & ~vsync_q;
   assign accept      = (state == WAIT_DE) || (state == ACTIVE);
   assign masked      = de & ~accept;
   assign frame_start = (state == WAIT_DE) && de;
   assign lv_fall     = ~lv & lv_q;

   rgb2bayer_dly #(
      .DEPTH (FV_LEAD),
      .W     (3*DW)
   ) u_dly (
      .clk       (clk),
      .rst       (rst),
      .din_de    (de & accept),
      .din       ({rin, gin, bin}),
      .dout_de   (d_de),
      .dout      (d_rgb),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_VS;
         vsync_q    <= 1'b0;
         fv         <= 1'b0;
         frame_done <= 1'b0;
         trail_cnt  <= '0;
      end else begin
         vsync_q    <= vsync;
         frame_done <= 1'b0;
         case (state)
            WAIT_VS: if (vs_rise) state <= WAIT_DE;
            WAIT_DE: if (de) begin
               fv    <= 1'b1;
               state <= ACTIVE;
            end
            ACTIVE:  if (vs_rise) state <= DRAIN;
            DRAIN:   if (!any_valid) begin
               trail_cnt <= 4'(FV_TRAIL);
               state     <= TRAIL;
            end
            TRAIL: begin
               if (trail_cnt == 4'd0) begin
                  fv         <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= WAIT_DE;
               end else begin
                  trail_cnt <= trail_cnt - 4'd1;
               end
            end
            default: state <= WAIT_VS;
         endcase
      end
   end

   // pix_par holds the parity of the next pixel; a fresh line (lv low) always starts at 0
   always_comb begin
      pix_cur = lv ? pix_par : 1'b0;
      sel     = {line_par, pix_cur} ^ PATTERN;
      pix     = '0;
      case (sel)
         SEL_R:          pix = d_rgb[3*DW-1:2*DW];
         SEL_GR, SEL_GB: pix = d_rgb[2*DW-1:DW];
         SEL_B:          pix = d_rgb[DW-1:0];
         default:        pix = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lv         <= 1'b0;
         dout       <= '0;
         pix_par    <= 1'b0;
         line_par   <= 1'b0;
         lv_q       <= 1'b0;
         masked_q   <= 1'b0;
         first_line <= 1'b0;
         len_cnt    <= '0;
         len_ref    <= '0;
         err        <= 1'b0;
      end else begin
         lv       <= d_de;
         dout     <= d_de ? pix : '0;
         lv_q     <= lv;
         masked_q <= masked;
         if (d_de) pix_par <= ~pix_cur;
         // line parity flips as lv drops so a back-to-back line already sees the new row
         if (frame_start)      line_par <= 1'b0;
         else if (lv && !d_de) line_par <= ~line_par;
         if (frame_start) begin
            first_line <= 1'b1;
            len_cnt    <= '0;
         end else if (lv_fall) begin
            len_cnt <= '0;
            if (first_line) begin
               len_ref    <= len_cnt;
               first_line <= 1'b0;
            end
         end else if (lv && len_cnt != '1) begin
            len_cnt <= len_cnt + LEN_W'(1);
         end
         err <= (masked & ~masked_q) |
                (lv_fall & ~first_line & (len_cnt != len_ref));
      end
   end

endmodule

// File: tb/tb_rgb2bayer.sv
// Directed bench for rgb2bayer: RGGB and BGGR instances share stimulus; outputs are logged per cycle and checked.
module tb_rgb2bayer;
   import rgb2bayer_pkg::*;

   localparam int DW = 12;
   localparam int NC = 2048;
   localparam int S_FV = 0, S_LV = 1, S_ERR = 2, S_FD = 3, S_DE = 4;

   logic          clk = 1'b0;
   logic          rst, vsync, de;
   logic [DW-1:0] rin, gin, bin;
   logic          fv0, lv0, fd0, err0, fv1, lv1, fd1, err1;
   logic [DW-1:0] dout0, dout1;

   rgb2bayer #(.DW(DW), .PATTERN(PAT_RGGB), .FV_LEAD(4), .FV_TRAIL(4)) dut0 (
      .clk(clk), .rst(rst), .vsync(vsync), .de(de), .rin(rin), .gin(gin), .bin(bin),
      .fv(fv0), .lv(lv0), .dout(dout0), .frame_done(fd0), .err(err0));

   rgb2bayer #(.DW(DW), .PATTERN(PAT_BGGR), .FV_LEAD(4), .FV_TRAIL(4)) dut1 (
      .clk(clk), .rst(rst), .vsync(vsync), .de(de), .rin(rin), .gin(gin), .bin(bin),
      .fv(fv1), .lv(lv1), .dout(dout1), .frame_done(fd1), .err(err1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit            fv_l [NC];
   bit            lv_l [NC];
   bit            err_l[NC];
   bit            fd_l [NC];
   bit            de_l [NC];
   logic [DW-1:0] d0_l [NC];
   logic [DW-1:0] d1_l [NC];

   always @(negedge clk) begin
      if (cyc < NC) begin
         fv_l[cyc]  <= fv0;
         lv_l[cyc]  <= lv0;
         err_l[cyc] <= err0;
         fd_l[cyc]  <= fd0;
         de_l[cyc]  <= de;
         d0_l[cyc]  <= dout0;
         d1_l[cyc]  <= dout1;
      end
   end

   int n_vec = 0, n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit sig(input int s, input int c);
      case (s)
         S_FV:    return fv_l[c];
         S_LV:    return lv_l[c];
         S_ERR:   return err_l[c];
         S_FD:    return fd_l[c];
         default: return de_l[c];
      endcase
   endfunction

   function automatic int first_hi(input int s, input int a, input int b);
      for (int c = a; c < b; c++) if (sig(s, c)) return c;
      return -1;
   endfunction

   function automatic int last_hi(input int s, input int a, input int b);
      for (int c = b - 1; c >= a; c--) if (sig(s, c)) return c;
      return -1;
   endfunction

   function automatic int ones(input int s, input int a, input int b);
      int n = 0;
      for (int c = a; c < b; c++) if (sig(s, c)) n++;
      return n;
   endfunction

   function automatic int rises(input int s, input int a, input int b);
      int n = 0;
      for (int c = a; c < b; c++) if (sig(s, c) && (c == a || !sig(s, c - 1))) n++;
      return n;
   endfunction

   function automatic int nth_rise(input int s, input int a, input int b, input int n);
      int k = 0;
      for (int c = a; c < b; c++) begin
         if (sig(s, c) && (c == a || !sig(s, c - 1))) begin
            if (k == n) return c;
            k++;
         end
      end
      return -1;
   endfunction

   function automatic int seg_len(input int s, input int c0, input int b);
      int n = 0;
      for (int c = c0; c < b && sig(s, c); c++) n++;
      return n;
   endfunction

   // Hand table with R=0x100, G=0x200, B=0x300; pat 0 = RGGB, pat 1 = BGGR
   function automatic logic [DW-1:0] exp_pix(input int pat, input int line, input int p);
      case ({pat[0], line[0], p[0]})
         3'b000:  return 12'h100;
         3'b001:  return 12'h200;
         3'b010:  return 12'h200;
         3'b011:  return 12'h300;
         3'b100:  return 12'h300;
         3'b101:  return 12'h200;
         3'b110:  return 12'h200;
         default: return 12'h100;
      endcase
   endfunction

   task automatic step(input bit d, input bit v);
      @(posedge clk);
      #1;
      de    = d;
      vsync = v;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   task automatic send_line(input int n, input bit vs_last);
      for (int i = 0; i < n; i++) step(1'b1, vs_last && (i == n - 1));
   endtask

   task automatic frame_checks(input string tag, input int s, input int e, input int l2len);
      int f_de, f_fv, f_lv, l_lv, l_fv, st, len, bad;
      f_de = first_hi(S_DE, s, e);
      f_fv = first_hi(S_FV, s, e);
      f_lv = first_hi(S_LV, s, e);
      l_lv = last_hi(S_LV, s, e);
      l_fv = last_hi(S_FV, s, e);
      check({tag, "_de2fv"}, f_fv - f_de, 1);
      check({tag, "_fv2lv"}, f_lv - f_fv, 4);
      check({tag, "_lvcnt"}, rises(S_LV, s, e), 4);
      check({tag, "_lv2fvfall"}, l_fv - l_lv, 5);
      check({tag, "_fdcnt"}, ones(S_FD, s, e), 1);
      check({tag, "_fdpos"}, first_hi(S_FD, s, e), l_fv + 1);
      for (int l = 0; l < 4; l++) begin
         len = (l == 2) ? l2len : 8;
         st  = nth_rise(S_LV, s, e, l);
         check($sformatf("%s_l%0d_found", tag, l), st >= 0, 1);
         if (st >= 0) begin
            check($sformatf("%s_l%0d_len", tag, l), seg_len(S_LV, st, e), len);
            for (int p = 0; p < len; p++) begin
               check($sformatf("%s_rggb_l%0d_p%0d", tag, l, p), d0_l[st + p], exp_pix(0, l, p));
               check($sformatf("%s_bggr_l%0d_p%0d", tag, l, p), d1_l[st + p], exp_pix(1, l, p));
            end
         end
      end
      bad = 0;
      for (int c = s; c < e; c++) if (!lv_l[c] && d0_l[c] != '0) bad++;
      check({tag, "_dout_idle0"}, bad, 0);
   endtask

   initial begin
      int sA, eA, sB, eB, sD, eD, sE, eE, sF, eF, i_vs, k_rst, st2;
      rst   = 1'b1;
      de    = 1'b0;
      vsync = 1'b0;
      rin   = 12'h100;
      gin   = 12'h200;
      bin   = 12'h300;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fv", fv0, 0);
      check("rst_lv", lv0, 0);
      check("rst_dout", dout0, 0);
      check("rst_fd", fd0, 0);
      check("rst_err", err0, 0);
      rst = 1'b0;

      // No vsync since reset: every line is masked
      sA = cyc + 1;
      for (int l = 0; l < 4; l++) begin
         send_line(8, 1'b0);
         idle(4);
      end
      idle(10);
      eA = cyc;
      check("novs_fv", ones(S_FV, sA, eA), 0);
      check("novs_lv", ones(S_LV, sA, eA), 0);
      check("novs_errcnt", rises(S_ERR, sA, eA), 4);
      check("novs_errpos", first_hi(S_ERR, sA, eA), first_hi(S_DE, sA, eA) + 1);
      check("novs_fd", ones(S_FD, sA, eA), 0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Clean 8x4 frame, vsync one cycle after the last de
      sB = cyc + 1;
      for (int l = 0; l < 3; l++) begin
         send_line(8, 1'b0);
         idle(4);
      end
      send_line(8, 1'b0);
      step(1'b0, 1'b1);
      idle(20);
      eB = cyc;
      frame_checks("clean", sB, eB, 8);
      check("clean_err", ones(S_ERR, sB, eB), 0);

      // Third line one pixel short
      sD = cyc + 1;
      send_line(8, 1'b0); idle(4);
      send_line(8, 1'b0); idle(4);
      send_line(7, 1'b0); idle(4);
      send_line(8, 1'b0);
      step(1'b0, 1'b1);
      idle(20);
      eD = cyc;
      frame_checks("short", sD, eD, 7);
      st2 = nth_rise(S_LV, sD, eD, 2);
      check("short_errcnt", ones(S_ERR, sD, eD), 1);
      check("short_errpos", first_hi(S_ERR, sD, eD), st2 + 8);

      // vsync on the last de, then stray de during DRAIN
      sE = cyc + 1;
      for (int l = 0; l < 3; l++) begin
         send_line(8, 1'b0);
         idle(4);
      end
      send_line(8, 1'b1);
      i_vs = cyc;
      step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      idle(20);
      eE = cyc;
      frame_checks("vslast", sE, eE, 8);
      check("vslast_lvtotal", ones(S_LV, sE, eE), 32);
      check("vslast_errcnt", ones(S_ERR, sE, eE), 1);
      check("vslast_errpos", first_hi(S_ERR, sE, eE), i_vs + 3);

      // Reset pulse while line 2 is on the output
      sF = cyc + 1;
      send_line(8, 1'b0); idle(4);
      send_line(8, 1'b0); idle(4);
      send_line(6, 1'b0);
      step(1'b1, 1'b0);
      rst   = 1'b1;
      k_rst = cyc;
      step(1'b1, 1'b0);
      rst = 1'b0;
      idle(4);
      send_line(8, 1'b0);
      idle(15);
      eF = cyc;
      check("mrst_pre_fv", fv_l[k_rst], 1);
      check("mrst_pre_lv", lv_l[k_rst], 1);
      check("mrst_pre_dout", d0_l[k_rst], 12'h200);
      check("mrst_fv", fv_l[k_rst + 1], 0);
      check("mrst_lv", lv_l[k_rst + 1], 0);
      check("mrst_dout", d0_l[k_rst + 1], 0);
      check("mrst_fd", ones(S_FD, sF, eF), 0);
      check("mrst_fv_after", ones(S_FV, k_rst + 1, eF), 0);
      check("mrst_lv_after", ones(S_LV, k_rst + 1, eF), 0);
      check("mrst_errpos", first_hi(S_ERR, k_rst + 1, eF), k_rst + 2);
      check("mrst_errcnt", rises(S_ERR, k_rst + 1, eF), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
